// File: rtl/stage2_regfile_if.sv
// Stage-2 register file bus: two asynchronous read ports with busy status,
// one write port and one scoreboard reservation port.
//   master : decode/writeback side; drives indices, write and reserve strobes
//   slave  : register file side; returns read data and busy flags
interface stage2_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              write_en;
    logic [ADDR_W-1:0] write_select;
    logic [DATA_W-1:0] write_data;
    logic              reserve_en;
    logic [ADDR_W-1:0] reserve_select;

    modport master (
        output rs1, rs2, write_en, write_select, write_data,
               reserve_en, reserve_select,
        input  rd1, rd2, rs1_busy, rs2_busy
    );

    modport slave (
        input  rs1, rs2, write_en, write_select, write_data,
               reserve_en, reserve_select,
        output rd1, rd2, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/stage2_regfile.sv
// Stage-2 integer register file with per-register busy scoreboard.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; clears all registers and busy bits
//   bus    : stage2_regfile_if.slave
//            rs1/rs2 -> rd1/rd2, rs1_busy/rs2_busy (combinational reads)
//            write_en/write_select/write_data (synchronous write)
//            reserve_en/reserve_select (marks a register busy)
// ZERO_REG=1 hardwires register 0 to zero and never busy.
// BYPASS=1 forwards a same-cycle write to matching read ports.
module stage2_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic             clk,
    input logic             rst_n,
    stage2_regfile_if.slave bus
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic [ADDR_W-1:0] rd_idx  [2];
    logic [DATA_W-1:0] rd_val  [2];
    logic              rd_busy [2];

    logic write_zero;
    assign write_zero = (ZERO_REG != 0) && (bus.write_select == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (bus.write_en && !write_zero) begin
                regs[bus.write_select] <= bus.write_data;
            end
            // Reservation outranks the write-back clear: a newly issued
            // producer supersedes the one completing this cycle.
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if ((ZERO_REG != 0) && (i == 0)) begin
                    busy[i] <= 1'b0;
                end else if (bus.reserve_en && (bus.reserve_select == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (bus.write_en && (bus.write_select == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign rd_idx[0] = bus.rs1;
    assign rd_idx[1] = bus.rs2;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            logic is_zero;
            logic wr_hit;
            logic rsv_hit;
            is_zero    = (ZERO_REG != 0) && (rd_idx[p] == '0);
            wr_hit     = bus.write_en && (bus.write_select == rd_idx[p]);
            rsv_hit    = bus.reserve_en && (bus.reserve_select == rd_idx[p]);
            rd_val[p]  = regs[rd_idx[p]];
            rd_busy[p] = busy[rd_idx[p]];
            if ((BYPASS != 0) && wr_hit) begin
                rd_val[p] = bus.write_data;
                if (!rsv_hit) begin
                    rd_busy[p] = 1'b0;
                end
            end
            // Reset must blank the bypass path too, not just the storage.
            if (is_zero || !rst_n) begin
                rd_val[p]  = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign bus.rd1      = rd_val[0];
    assign bus.rd2      = rd_val[1];
    assign bus.rs1_busy = rd_busy[0];
    assign bus.rs2_busy = rd_busy[1];

endmodule

// File: tb/tb_stage2_regfile.sv
// Bench for stage2_regfile: one BYPASS=1 and one BYPASS=0 instance share the
// same stimulus; a reference model produces expected outputs for both.
module tb_stage2_regfile;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]  rs1, rs2, ws, rsel;
    logic [31:0] wd;
    logic        we, re;

    stage2_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
    stage2_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    assign bus_b.rs1 = rs1;            assign bus_n.rs1 = rs1;
    assign bus_b.rs2 = rs2;            assign bus_n.rs2 = rs2;
    assign bus_b.write_en = we;        assign bus_n.write_en = we;
    assign bus_b.write_select = ws;    assign bus_n.write_select = ws;
    assign bus_b.write_data = wd;      assign bus_n.write_data = wd;
    assign bus_b.reserve_en = re;      assign bus_n.reserve_en = re;
    assign bus_b.reserve_select = rsel; assign bus_n.reserve_select = rsel;

    stage2_regfile #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
        u_dut_byp (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    stage2_regfile #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0))
        u_dut_nobyp (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_busy [32];

    typedef struct packed {
        logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
        logic        b1_b, b2_b, b1_n, b2_n;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];

    function automatic void model_read(input logic [4:0] a, input bit byp,
                                       output logic [31:0] d, output logic b);
        d = m_regs[a];
        b = m_busy[a];
        if (byp && we && ws == a) begin
            d = wd;
            if (!(re && rsel == a)) b = 1'b0;
        end
        if (a == 5'd0 || !rst_n) begin
            d = '0;
            b = 1'b0;
        end
    endfunction

    function automatic void model_commit();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && ws != 5'd0) m_regs[ws] = wd;
            if (we) m_busy[ws] = 1'b0;
            if (re) m_busy[rsel] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endfunction

    // One cycle: inputs already applied just after a rising edge. Expected
    // outputs go into the scoreboard, are compared on the falling edge, then
    // the model takes the same rising edge as the DUTs.
    task automatic step(input string tag);
        exp_t e;
        exp_t g;
        model_read(rs1, 1'b1, e.rd1_b, e.b1_b);
        model_read(rs2, 1'b1, e.rd2_b, e.b2_b);
        model_read(rs1, 1'b0, e.rd1_n, e.b1_n);
        model_read(rs2, 1'b0, e.rd2_n, e.b2_n);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            tag = tag_q.pop_front();
            g.rd1_b = bus_b.rd1;  g.rd2_b = bus_b.rd2;
            g.rd1_n = bus_n.rd1;  g.rd2_n = bus_n.rd2;
            check({tag, "_rd1_byp"},   g.rd1_b, e.rd1_b);
            check({tag, "_rd2_byp"},   g.rd2_b, e.rd2_b);
            check({tag, "_rd1_nobyp"}, g.rd1_n, e.rd1_n);
            check({tag, "_rd2_nobyp"}, g.rd2_n, e.rd2_n);
            check({tag, "_b1_byp"},   {31'd0, bus_b.rs1_busy}, {31'd0, e.b1_b});
            check({tag, "_b2_byp"},   {31'd0, bus_b.rs2_busy}, {31'd0, e.b2_b});
            check({tag, "_b1_nobyp"}, {31'd0, bus_n.rs1_busy}, {31'd0, e.b1_n});
            check({tag, "_b2_nobyp"}, {31'd0, bus_n.rs2_busy}, {31'd0, e.b2_n});
        end
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        re = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0; ws = '0; rsel = '0; wd = '0; we = 1'b0; re = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'hFFFF_FFFF;
            m_busy[i] = 1'b1;
        end
        @(posedge clk);
        #1;

        // Reset: every index reads zero and not busy
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            step("rst_rd");
        end
        rst_n = 1'b1;

        // Plain write, visible next cycle; write to r0 dropped
        we = 1'b1; ws = 5'd5; wd = 32'hDEAD_BEEF; rs1 = 5'd5; rs2 = 5'd0;
        step("wr5");
        idle(); step("rd5");
        we = 1'b1; ws = 5'd0; wd = 32'h0000_1234; rs1 = 5'd0; rs2 = 5'd0;
        step("wr0");
        idle(); step("rd0");

        // Same-cycle bypass on port 2
        we = 1'b1; ws = 5'd7; wd = 32'hA5A5_A5A5; rs1 = 5'd5; rs2 = 5'd7;
        step("byp7");
        idle(); step("rd7");

        // Reserve, observe busy, write back with bypass-masked busy
        re = 1'b1; rsel = 5'd9; rs1 = 5'd9; rs2 = 5'd9;
        step("rsv9");
        idle(); step("busy9");
        we = 1'b1; ws = 5'd9; wd = 32'h0000_0055;
        step("wb9");
        idle(); step("clr9");

        // Reserve and write same index: reserve wins, data still written
        re = 1'b1; rsel = 5'd3; we = 1'b1; ws = 5'd3; wd = 32'h0000_0077;
        rs1 = 5'd3; rs2 = 5'd3;
        step("rsvwr3");
        idle(); step("after3");
        re = 1'b1; rsel = 5'd0; rs1 = 5'd0; rs2 = 5'd3;
        step("rsv0");
        idle(); step("after0");

        // Asynchronous reset asserted mid-cycle during a write
        we = 1'b1; ws = 5'd5; wd = 32'hCAFE_F00D; re = 1'b1; rsel = 5'd11;
        rs1 = 5'd5; rs2 = 5'd3;
        #2 rst_n = 1'b0;
        step("rst_mid");
        idle();
        rst_n = 1'b1;
        step("post_rst");
        rs1 = 5'd11; rs2 = 5'd9;
        step("post_rst2");

        // Random traffic with forced port and write/reserve collisions
        for (int c = 0; c < 10000; c++) begin
            rs1  = 5'($urandom_range(0, 31));
            rs2  = ($urandom_range(0, 9) == 0) ? rs1 : 5'($urandom_range(0, 31));
            we   = 1'($urandom_range(0, 1));
            ws   = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
            wd   = $urandom;
            re   = 1'($urandom_range(0, 1));
            rsel = ($urandom_range(0, 9) == 0) ? ws : 5'($urandom_range(0, 31));
            step("rand");
        end
        idle();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
